mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one shared RAM with a 3-state FSM.
// Define MEM_ARBITER_STARVE_EN to build the instruction-fetch starvation guard.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [31:0] addr_q, store_q;
  logic        ren_q, wen_q;
  logic        ireq, dreq, starve;
  logic        grant_i, grant_d, release_bus;

  assign ireq = iREN;
  assign dreq = dREN | dWEN;

`ifdef MEM_ARBITER_STARVE_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt;

  // Counts data grants that overtook a waiting fetch; saturates at 7.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && iREN && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign starve = (starve_cnt >= LIMIT);
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && !(ireq && starve)) begin
          next_state = DGNT;
          grant_d    = 1'b1;
        end else if (ireq) begin
          next_state = IGNT;
          grant_i    = 1'b1;
        end
      end
      IGNT:    if (ramready || !ireq) next_state = IDLE;
      DGNT:    if (ramready || !dreq) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are cleared on the edge that returns to IDLE, so an abort drops them one cycle later.
  assign release_bus = (state != IDLE) && (next_state == IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i) begin
        addr_q  <= iaddr;
        store_q <= '0;
        ren_q   <= 1'b1;
        wen_q   <= 1'b0;
      end else if (grant_d) begin
        addr_q  <= daddr;
        store_q <= dstore;
        ren_q   <= ~dWEN;
        wen_q   <= dWEN;
      end else if (release_bus) begin
        ren_q <= 1'b0;
        wen_q <= 1'b0;
      end
    end
  end

  always_comb begin
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = ren_q;
    ramWEN    = wen_q;
    ramaddr   = addr_q;
    ramstore  = store_q;
    arb_state = state;
    if ((state == IGNT) && ramready) begin
      iwait = 1'b0;
      iload = ramload;
    end
    if ((state == DGNT) && ramready) begin
      dwait = 1'b0;
      if (ren_q) dload = ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// scored against an ordered-memory reference model.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ramready;
  logic [1:0]  arb_state;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .arb_state(arb_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned total = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM model
  logic [31:0] ram_mem [logic [31:0]];
  bit          ram_hold = 0;
  bit          rand_lat = 0;
  int unsigned fix_lat  = 0;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  initial begin
    int unsigned acc_cyc = 0;
    int unsigned cur_lat = 0;
    ramready = 1'b0;
    ramload  = '0;
    forever begin
      @(posedge CLK); #1;
      if (ramREN || ramWEN) begin
        if (acc_cyc == 0) cur_lat = rand_lat ? $urandom_range(0, 3) : fix_lat;
        if (!ram_hold && acc_cyc >= cur_lat) begin
          ramready = 1'b1;
          if (ramWEN) begin
            ram_mem[ramaddr] = ramstore;
            ramload = $urandom;
          end else begin
            ramload = ram_rd(ramaddr);
          end
        end else begin
          ramready = 1'b0;
          ramload  = $urandom;
        end
        acc_cyc++;
      end else begin
        ramready = 1'b0;
        ramload  = $urandom;
        acc_cyc  = 0;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  bit   sb_en = 0;
  logic [31:0] ref_mem [logic [31:0]];

  always @(negedge CLK) begin
    exp_t e;
    if (iwait) chk("iload_zero_while_wait", iload, '0);
    if (dwait) chk("dload_zero_while_wait", dload, '0);
    if (arb_state == 2'd0) chk("idle_strobes_low", {30'd0, ramREN, ramWEN}, '0);
    if (sb_en && !iwait) begin
      if (iq.size() == 0) begin
        total++;
        $display("FAIL i_unexpected: got iwait=0 required no completion at %0t", $time);
      end else begin
        e = iq.pop_front();
        chk("i_ramaddr", ramaddr, e.addr);
        chk("i_ramREN", ramREN, 1);
        chk("i_iload", iload, e.data);
      end
    end
    if (sb_en && !dwait) begin
      if (dq.size() == 0) begin
        total++;
        $display("FAIL d_unexpected: got dwait=0 required no completion at %0t", $time);
      end else begin
        e = dq.pop_front();
        chk("d_ramaddr", ramaddr, e.addr);
        chk("d_ramWEN", ramWEN, e.wr);
        chk("d_ramREN", ramREN, !e.wr);
        if (e.wr) chk("d_ramstore", ramstore, e.data);
        else      chk("d_dload", dload, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic i_traffic(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      exp_t e;
      bit   got;
      repeat ($urandom_range(0, 3)) cyc();
      e.addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      e.wr   = 1'b0;
      e.data = init_val(e.addr);
      iq.push_back(e);
      iaddr = e.addr;
      iREN  = 1'b1;
      got   = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        neg();
        if (!iwait) got = 1;
      end
      chk("i_completion_in_time", 32'(got), 1);
      cyc();
      iREN = 1'b0;
      if (!got) break;
    end
  endtask

  task automatic d_traffic(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      exp_t        e;
      bit          got;
      int unsigned op;
      repeat ($urandom_range(0, 3)) cyc();
      op     = $urandom_range(0, 2);
      e.addr = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      e.wr   = (op != 0);
      if (e.wr) begin
        e.data = $urandom;
        ref_mem[e.addr] = e.data;
        dstore = e.data;
      end else begin
        e.data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_val(e.addr);
        dstore = $urandom;
      end
      dq.push_back(e);
      daddr = e.addr;
      dREN  = (op != 1);
      dWEN  = (op != 0);
      got   = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        neg();
        if (!dwait) got = 1;
      end
      chk("d_completion_in_time", 32'(got), 1);
      cyc();
      dREN = 1'b0;
      dWEN = 1'b0;
      if (!got) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  got_g [8];
    logic [1:0]  exp_g;
    logic [1:0]  prev;
    int unsigned n;

    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    #2 nRST = 1'b0;
    #2;
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_arb_state", arb_state, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    neg(); neg();
    nRST = 1'b1;

    // Instruction fetch, RAM answers in the second grant cycle
    ram_mem[32'h40] = 32'hDEADBEEF;
    fix_lat = 1;
    cyc(); iREN = 1'b1; iaddr = 32'h40;
    @(posedge CLK);
    neg();
    chk("f1_state_ignt", arb_state, 1);
    chk("f1_ramaddr", ramaddr, 32'h40);
    chk("f1_ramREN", ramREN, 1);
    chk("f1_iwait_c1", iwait, 1);
    neg();
    chk("f1_iwait_c2", iwait, 0);
    chk("f1_iload", iload, 32'hDEADBEEF);
    cyc(); iREN = 1'b0;
    neg();
    chk("f1_state_idle", arb_state, 0);

    // Simultaneous fetch and write: data first, then fetch after the bubble
    ram_mem[32'h44] = 32'hCAFEF00D;
    fix_lat = 0;
    cyc(); iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    @(posedge CLK);
    neg();
    chk("tie_state_dgnt", arb_state, 2);
    chk("tie_ramWEN", ramWEN, 1);
    chk("tie_ramREN", ramREN, 0);
    chk("tie_ramstore", ramstore, 32'h1234);
    chk("tie_ramaddr", ramaddr, 32'h80);
    chk("tie_dwait", dwait, 0);
    chk("tie_iwait_held", iwait, 1);
    cyc(); dWEN = 1'b0;
    neg();
    chk("tie_bubble", arb_state, 0);
    neg();
    chk("tie_state_ignt", arb_state, 1);
    chk("tie_i_ramaddr", ramaddr, 32'h44);
    chk("tie_iwait", iwait, 0);
    chk("tie_iload", iload, 32'hCAFEF00D);
    cyc(); iREN = 1'b0;
    neg();
    chk("tie_idle", arb_state, 0);

    // Read and write together behave as a write
    cyc(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h84; dstore = 32'h55AA;
    @(posedge CLK);
    neg();
    chk("rw_ramWEN", ramWEN, 1);
    chk("rw_ramREN", ramREN, 0);
    chk("rw_dwait", dwait, 0);
    cyc(); dREN = 1'b0; dWEN = 1'b0;
    neg();
    chk("rw_idle", arb_state, 0);

    // Data abort while RAM is stalled
    ram_hold = 1;
    cyc(); dREN = 1'b1; daddr = 32'h88;
    @(posedge CLK);
    neg();
    chk("ab_state_dgnt", arb_state, 2);
    chk("ab_ramREN", ramREN, 1);
    chk("ab_dwait_c1", dwait, 1);
    cyc(); dREN = 1'b0;
    neg();
    chk("ab_state_still_dgnt", arb_state, 2);
    chk("ab_strobe_still_high", ramREN, 1);
    chk("ab_dwait_c2", dwait, 1);
    neg();
    chk("ab_state_idle", arb_state, 0);
    chk("ab_ramREN_low", ramREN, 0);
    chk("ab_dwait_c3", dwait, 1);
    ram_hold = 0;

    // Reset in the middle of a stalled fetch
    ram_hold = 1;
    cyc(); iREN = 1'b1; iaddr = 32'h90;
    @(posedge CLK);
    neg();
    chk("mr_state_ignt", arb_state, 1);
    chk("mr_ramREN", ramREN, 1);
    #2 nRST = 1'b0;
    #1;
    chk("mr_state_rst", arb_state, 0);
    chk("mr_ramREN_rst", ramREN, 0);
    chk("mr_ramaddr_rst", ramaddr, 0);
    chk("mr_iwait_rst", iwait, 1);
    chk("mr_iload_rst", iload, 0);
    neg();
    chk("mr_iwait_in_rst", iwait, 1);
    nRST = 1'b1;
    neg();
    chk("mr_restart_ignt", arb_state, 1);
    ram_hold = 0;
    neg();
    chk("mr_restart_done", iwait, 0);
    cyc(); iREN = 1'b0;
    neg();
    chk("mr_idle", arb_state, 0);

    // Both ports held continuously: grant order from the tie/starvation rule
    neg(); nRST = 1'b0;
    neg(); nRST = 1'b1;
    fix_lat = 0;
    cyc(); iREN = 1'b1; iaddr = 32'hA0; dREN = 1'b1; dWEN = 1'b0; daddr = 32'hB0;
    n = 0;
    prev = 2'd0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      neg();
      if (arb_state != 2'd0 && prev == 2'd0) begin
        got_g[n] = arb_state;
        n++;
      end
      prev = arb_state;
    end
    chk("order_grant_count", n, 8);
    for (int unsigned k = 0; k < n; k++) begin
`ifdef MEM_ARBITER_STARVE_EN
      exp_g = (k % (LIMIT + 1) == LIMIT) ? 2'd1 : 2'd2;
`else
      exp_g = 2'd2;
`endif
      chk($sformatf("order_grant_%0d", k), got_g[k], exp_g);
    end
    cyc(); iREN = 1'b0; dREN = 1'b0;
    neg(); neg();

    // Randomized concurrent traffic against the scoreboard
    rand_lat = 1;
    sb_en    = 1;
    fork
      i_traffic(40);
      d_traffic(40);
    join
    repeat (4) neg();
    sb_en = 0;
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
